spi_read_arbiter: RTL
=====================

# spi_read_arbiter

Shares the single `spi_read_byte` engine between two byte-read requesters: port 0 (instruction fetch from the CPU wrapper) and port 1 (data/operand reads). It accepts one request at a time, issues the engine start pulse, waits for the byte and returns it to the winning requester with a done pulse. A watchdog turns a missing engine `done` into an error response, so the fetch FSM cannot hang on a dead SPI RAM.

## Interface
- `ADDR_W`, 16, SPI byte address width
- `DATA_W`, 8, returned data width
- `TIMEOUT_CYCLES`, 255, max cycles in WAIT before an error response (≥2)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `req0_valid`  in  1  port 0 (fetch) request; held until `req0_ack`
- `req0_addr`  in  ADDR_W  port 0 address; stable while valid
- `req0_ack`  out  1  one-cycle accept pulse
- `req0_done`  out  1  one-cycle response pulse
- `req0_data`  out  DATA_W  byte; valid only with `req0_done`
- `req0_err`  out  1  timeout flag; valid only with `req0_done`
- `req1_*`  same set as port 0, for port 1 (data reads)
- `eng_start`  out  1  start pulse to `spi_read_byte`
- `eng_addr`  out  ADDR_W  latched address to engine
- `eng_busy`  in  1  engine busy
- `eng_done`  in  1  engine byte-ready pulse
- `eng_data`  in  DATA_W  engine byte

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `eng_busy`=0 and any `reqN_valid`, pick a winner, latch owner and address, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `eng_start`=1 and `reqN_ack`=1 for the owner, both decoded from the state register. Clear the timer, go to WAIT.
- WAIT: the timer increments each cycle.
  - `eng_done`=1: latch `eng_data`, clear the error flag, go to RESP.
  - Otherwise, if timer = TIMEOUT_CYCLES−1: set the error flag, latch data = all ones (0xFF), go to RESP.
- RESP: owner's `reqN_done`=1 with the latched data and error flag; the other port's done stays 0. Update last-owner, go to IDLE.
- Arbitration, default: fixed priority, port 0 beats port 1.
- `eng_addr` always drives the latched address. `reqN_data`/`reqN_err` hold their last value between done pulses.
- Requester drops valid after seeing ack. A valid still high in the IDLE cycle after RESP counts as a new request.

## Timing
- Reset values: state IDLE; `eng_start`, all ack/done/err outputs 0; data outputs 0; `eng_addr` 0; timer 0; last-owner = 1.
- Valid seen in IDLE at cycle t → ack and `eng_start` at t+1.
- `eng_done` at cycle d → `reqN_done` at d+1 → IDLE at d+2. The earliest next ack is at d+3.
- Timeout: `reqN_done` with err=1 exactly TIMEOUT_CYCLES+1 cycles after ISSUE.
- `eng_done` on the timeout cycle: done wins, err=0, real data returned.
- `eng_done` outside WAIT is ignored. A request while `eng_busy`=1 waits in IDLE.
- Simultaneous valids: one ack only; the loser keeps valid high and is served next.
- `rst_n` low mid-transaction: all outputs return to reset values next cycle, no done is emitted, and the pending request is dropped. Requesters and the engine reset on the same `rst_n`.

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin. When both valids are high, grant the port that is not last-owner. Reset last-owner=1, so port 0 wins the first tie. A single valid is always granted.
- Undefined: fixed priority port 0 > port 1; the last-owner register is not built.

## Structure
- Package `spi_arb_pkg`: state encoding localparams, port IDs (`PORT_FETCH`=0, `PORT_DATA`=1), `ERR_DATA` = 8'hFF.
- One sub-module, `spi_arb_pick`: combinational winner select from the two valids and last-owner, containing the `SPI_ARB_RR_EN` branch.
- The FSM, timer and latches live in the top module.

## Test plan
- Port 0 read, addr 0x0012; engine returns 0xA5 four cycles after start → one `req0_ack`, `eng_addr`=0x0012, `req0_done` with 0xA5, err=0; port 1 outputs stay 0.
- Both valid in the same cycle (0x0001 / 0x0800), default build → port 0 served first, then port 1; exactly two `eng_start` pulses.
- Same stimulus with `SPI_ARB_RR_EN`, both held valid for 4 transactions → grant order 0,1,0,1.
- Engine never asserts done, TIMEOUT_CYCLES=8 → `req1_done` with err=1 and data 0xFF exactly 9 cycles after ISSUE; a following request is accepted normally.
- `eng_busy` held high with valid pending → no ack until busy drops; ack exactly 1 cycle after the first IDLE cycle with busy=0.
- `rst_n` low during WAIT → next cycle all outputs 0 and no done; after release, a fresh request completes normally.

Source files
------------

// File: rtl/spi_read_arbiter_pkg.sv
// spi_arb_pkg: state encodings, port IDs and error byte shared by spi_read_arbiter (SPI_ARB_RR_EN selects round-robin)
package spi_arb_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [7:0] ERR_DATA = 8'hFF;
endpackage

// File: rtl/spi_read_arbiter_if.sv
// spi_read_arbiter_if: two byte-read requester ports plus the spi_read_byte engine handshake
interface spi_read_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ack;
    logic              req0_done;
    logic [DATA_W-1:0] req0_data;
    logic              req0_err;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ack;
    logic              req1_done;
    logic [DATA_W-1:0] req1_data;
    logic              req1_err;

    logic              eng_start;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_busy;
    logic              eng_done;
    logic [DATA_W-1:0] eng_data;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, eng_busy, eng_done, eng_data,
        output req0_ack, req0_done, req0_data, req0_err,
        output req1_ack, req1_done, req1_data, req1_err,
        output eng_start, eng_addr
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, eng_busy, eng_done, eng_data,
        input  req0_ack, req0_done, req0_data, req0_err,
        input  req1_ack, req1_done, req1_data, req1_err,
        input  eng_start, eng_addr
    );
endinterface

// File: rtl/spi_read_arbiter_pick.sv
// spi_arb_pick: combinational winner select; SPI_ARB_RR_EN turns fixed priority into round-robin
module spi_arb_pick
    import spi_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
`ifdef SPI_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic any,
    output logic winner
);
    // On a tie round-robin grants the port that did not go last; a lone valid always wins
    always_comb begin
        any = valid0 | valid1;
`ifdef SPI_ARB_RR_EN
        winner = (valid0 && valid1) ? ~last_owner : (valid0 ? PORT_FETCH : PORT_DATA);
`else
        winner = valid0 ? PORT_FETCH : PORT_DATA;
`endif
    end
endmodule

// File: rtl/spi_read_arbiter.sv
// spi_read_arbiter: shares one spi_read_byte engine between fetch and data ports with a done watchdog (SPI_ARB_RR_EN: round-robin)
module spi_read_arbiter
    import spi_arb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst_n,
    spi_read_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              owner;
    logic [TW-1:0]     timer;
    logic              any;
    logic              winner;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] resp_data;

`ifdef SPI_ARB_RR_EN
    logic last_owner;

    spi_arb_pick u_pick (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_owner (last_owner),
        .any        (any),
        .winner     (winner)
    );
`else
    spi_arb_pick u_pick (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .any    (any),
        .winner (winner)
    );
`endif

    // Address of the winner and the byte to return: engine data, or all ones on timeout
    always_comb begin
        grant_addr = winner ? bus.req1_addr : bus.req0_addr;
        resp_data  = bus.eng_done ? bus.eng_data : '1;
    end

    // Sequencer IDLE -> ISSUE -> WAIT -> RESP; every output is registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= PORT_FETCH;
            timer         <= '0;
            bus.eng_start <= 1'b0;
            bus.eng_addr  <= '0;
            bus.req0_ack  <= 1'b0;
            bus.req0_done <= 1'b0;
            bus.req0_data <= '0;
            bus.req0_err  <= 1'b0;
            bus.req1_ack  <= 1'b0;
            bus.req1_done <= 1'b0;
            bus.req1_data <= '0;
            bus.req1_err  <= 1'b0;
`ifdef SPI_ARB_RR_EN
            last_owner    <= PORT_DATA;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.eng_busy && any) begin
                        owner         <= winner;
                        bus.eng_addr  <= grant_addr;
                        bus.eng_start <= 1'b1;
                        bus.req0_ack  <= (winner == PORT_FETCH);
                        bus.req1_ack  <= (winner == PORT_DATA);
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.eng_start <= 1'b0;
                    bus.req0_ack  <= 1'b0;
                    bus.req1_ack  <= 1'b0;
                    timer         <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.eng_done || timer == TMAX) begin
                        bus.req0_done <= (owner == PORT_FETCH);
                        bus.req1_done <= (owner == PORT_DATA);
                        if (owner == PORT_FETCH) begin
                            bus.req0_data <= resp_data;
                            bus.req0_err  <= ~bus.eng_done;
                        end else begin
                            bus.req1_data <= resp_data;
                            bus.req1_err  <= ~bus.eng_done;
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    bus.req0_done <= 1'b0;
                    bus.req1_done <= 1'b0;
`ifdef SPI_ARB_RR_EN
                    last_owner    <= owner;
`endif
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
